mem_ctrl: RTL and testbench

- Memory controller between the 8-bit byte-serial RAM port and two clients: instruction fetch (IF) and the MEM stage.
- Serialises byte/half/word loads and stores, little-endian, into single-byte RAM accesses.
- Returns results to the MEM stage through the addr_needed / mem_working / mem_available handshake. The MEM stage does sign extension; this block does none.
- A MEM request wins over an IF request when both are pending.

---
 rtl/mem_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Memory controller between an 8-bit byte-serial RAM and two clients: the
// instruction fetch unit (IF) and the MEM pipeline stage. Byte, halfword and
// word loads/stores are serialised into single-byte RAM accesses in
// little-endian order. A pending MEM request wins over a pending IF request.
// No sign extension is done here; loads return zero-extended raw bytes.
//
// Optional feature (compile-time macro MEMCTRL_IF_ABORT_EN):
//   defined : dropping if_req during a fetch abandons it (back to IDLE, no
//             if_valid, if_data unchanged).
//   absent  : a fetch always runs to completion once accepted.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   if_req/if_addr IF fetch request (32-bit word), held until if_valid
//   if_valid       one-cycle completion pulse, if_data valid with it
//   if_data        fetched word
//   addr_needed    a new request is accepted at the next edge
//   mem_addr       MEM byte address
//   mem_wr         0 = load, 1 = store
//   mem_data       store data, low bytes used
//   mem_cnf        0 = none, 1 = byte, 2 = half, 3 = word
//   mem_working    MEM transaction in flight
//   mem_available  one-cycle MEM completion pulse
//   data_out       load result (zero-extended), 0 after a store
//   ram_a          RAM byte address
//   ram_wr         RAM write enable
//   ram_dout       RAM write data
//   ram_din        RAM read data, one cycle after the address
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction fetch client
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_valid,
  output logic [31:0]           if_data,
  // MEM stage client
  output logic                  addr_needed,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wr,
  input  logic [31:0]           mem_data,
  input  logic [1:0]            mem_cnf,
  output logic                  mem_working,
  output logic                  mem_available,
  output logic [31:0]           data_out,
  // byte-serial RAM
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_FETCH,
    S_DONE_M,
    S_DONE_I
  } state_t;

  state_t                state;
  // cnt is the 1-based number of the current cycle within LOAD/STORE/FETCH.
  logic [2:0]            cnt;
  logic [2:0]            nbytes;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic [31:0]           ins_word;
  logic [1:0]            sample_idx;
  logic [2:0]            req_n;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  // Byte count of the request on the MEM port.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    req_n = 3'd4;
    case (mem_cnf)
      2'd1:    req_n = 3'd1;
      2'd2:    req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  // In cycle cnt, ram_din carries the byte addressed in cycle cnt-1, i.e. byte
  // cnt-2. ins_word is the assembled word with that byte merged in.
  assign sample_idx = cnt[1:0] - 2'd2;

  always_comb begin
    ins_word = rdata;
    ins_word[{sample_idx, 3'b000} +: 8] = ram_din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: datapath registers are reset too, because every output must read 0 after reset.
      state         <= S_IDLE;
      cnt           <= '0;
      nbytes        <= '0;
      base          <= '0;
      wdata         <= '0;
      rdata         <= '0;
      if_valid      <= 1'b0;
      if_data       <= '0;
      addr_needed   <= 1'b0;
      mem_working   <= 1'b0;
      mem_available <= 1'b0;
      data_out      <= '0;
      ram_a         <= '0;
      ram_wr        <= 1'b0;
      ram_dout      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
      if_valid      <= 1'b0;
      mem_available <= 1'b0;

      unique case (state)
        S_IDLE, S_DONE_M, S_DONE_I: begin
          if (!addr_needed) begin
            // First cycle out of reset: outputs are still all zero, so no
            // request may be taken yet.
            addr_needed <= 1'b1;
          end else if (mem_cnf != 2'd0) begin
            base        <= mem_addr;
            wdata       <= mem_data;
            nbytes      <= req_n;
            rdata       <= '0;
            cnt         <= 3'd1;
            addr_needed <= 1'b0;
            mem_working <= 1'b1;
            ram_a       <= mem_addr;
            if (mem_wr) begin
              state    <= S_STORE;
              ram_wr   <= 1'b1;
              ram_dout <= mem_data[7:0];
            end else begin
              state  <= S_LOAD;
              ram_wr <= 1'b0;
            end
          end else if (if_req) begin
            state       <= S_FETCH;
            base        <= if_addr;
            nbytes      <= 3'd4;
            rdata       <= '0;
            cnt         <= 3'd1;
            addr_needed <= 1'b0;
            mem_working <= 1'b0;
            ram_a       <= if_addr;
            ram_wr      <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_STORE: begin
          if (cnt == nbytes) begin
            state         <= S_DONE_M;
            ram_wr        <= 1'b0;
            mem_working   <= 1'b0;
            mem_available <= 1'b1;
            data_out      <= '0;
            addr_needed   <= 1'b1;
          end else begin
            cnt      <= cnt + 3'd1;
            ram_a    <= base + ADDR_WIDTH'(cnt);
            ram_dout <= byte_sel(wdata, cnt[1:0]);
          end
        end

        S_LOAD, S_FETCH: begin
`ifdef MEMCTRL_IF_ABORT_EN
          if (state == S_FETCH && !if_req) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_needed <= 1'b1;
          end else
`endif
          begin
            // Advance the address while bytes remain; the final cycle holds it.
            if (cnt < nbytes) ram_a <= base + ADDR_WIDTH'(cnt);
            if (cnt >= 3'd2)  rdata <= ins_word;
            if (cnt == nbytes + 3'd1) begin
              addr_needed <= 1'b1;
              if (state == S_LOAD) begin
                state         <= S_DONE_M;
                data_out      <= ins_word;
                mem_available <= 1'b1;
                mem_working   <= 1'b0;
              end else begin
                state    <= S_DONE_I;
                if_data  <= ins_word;
                if_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Self-checking bench for mem_ctrl. The bench plays the byte RAM, keeps a
// transaction-level reference model (cycle offset since acceptance plus plain
// address arithmetic and a reference byte image), and compares every DUT
// output against it on each falling edge. Directed scenarios add
// hand-computed literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_valid;
  logic [31:0]   if_data;
  logic          addr_needed;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [31:0]   mem_data;
  logic [1:0]    mem_cnf;
  logic          mem_working;
  logic          mem_available;
  logic [31:0]   data_out;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_valid      (if_valid),
    .if_data       (if_data),
    .addr_needed   (addr_needed),
    .mem_addr      (mem_addr),
    .mem_wr        (mem_wr),
    .mem_data      (mem_data),
    .mem_cnf       (mem_cnf),
    .mem_working   (mem_working),
    .mem_available (mem_available),
    .data_out      (data_out),
    .ram_a         (ram_a),
    .ram_wr        (ram_wr),
    .ram_dout      (ram_dout),
    .ram_din       (ram_din)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM environment and reference byte image
  // ---------------------------------------------------------------------------
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] fill_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : fill_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  always @(posedge clk) begin
    ram_din <= ram_rd(ram_a);
    if (ram_wr === 1'b1) ram[ram_a] = ram_dout;
  end

  // ---------------------------------------------------------------------------
  // Reference model: kind of transaction, its byte count and the number of
  // the cycle now running since acceptance.
  // ---------------------------------------------------------------------------
  localparam int K_NONE = 0, K_LOAD = 1, K_STORE = 2, K_FETCH = 3;

  int          m_kind = K_NONE;
  int          m_t, m_n;
  logic [31:0] m_addr, m_data;
  bit          m_ready, m_can, m_acc_mem;
  logic [31:0] m_word;

  bit          e_if_valid, e_addr_needed, e_mem_working, e_mem_available;
  bit          e_ram_wr, e_a_chk;
  logic [31:0] e_if_data, e_data_out, e_ram_a;
  logic [7:0]  e_ram_dout;

  function automatic int done_t(input int kind, input int n);
    return (kind == K_STORE) ? n + 1 : n + 2;
  endfunction

  always @(posedge clk) begin
    m_acc_mem = 1'b0;
    if (!rst) begin
      m_kind = K_NONE; m_t = 0; m_ready = 1'b0;
      e_if_valid = 0; e_addr_needed = 0; e_mem_working = 0; e_mem_available = 0;
      e_ram_wr = 0; e_a_chk = 1; e_ram_a = '0; e_ram_dout = '0;
      e_if_data = '0; e_data_out = '0;
    end else begin
      m_can = m_ready && (m_kind == K_NONE || m_t == done_t(m_kind, m_n));
      if (m_can) begin
        if (mem_cnf != 2'd0) begin
          m_kind = mem_wr ? K_STORE : K_LOAD;
          m_n    = (mem_cnf == 2'd3) ? 4 : int'(mem_cnf);
          m_addr = mem_addr; m_data = mem_data; m_t = 1; m_acc_mem = 1'b1;
          if (mem_wr)
            for (int k = 0; k < m_n; k++) ref_mem[m_addr + 32'(k)] = m_data[8*k +: 8];
        end else if (if_req) begin
          m_kind = K_FETCH; m_n = 4; m_addr = if_addr; m_t = 1;
        end else begin
          m_kind = K_NONE; m_t = 0;
        end
      end else if (m_kind != K_NONE) begin
`ifdef MEMCTRL_IF_ABORT_EN
        if (m_kind == K_FETCH && !if_req) begin
          m_kind = K_NONE; m_t = 0;
        end else
`endif
        m_t++;
      end
      m_ready = 1'b1;

      e_if_valid = 0; e_mem_available = 0; e_ram_wr = 0; e_a_chk = 0; e_mem_working = 0;
      e_addr_needed = (m_kind == K_NONE) || (m_t == done_t(m_kind, m_n));
      if (m_kind == K_STORE) begin
        if (m_t <= m_n) begin
          e_ram_wr = 1; e_a_chk = 1; e_mem_working = 1;
          e_ram_a    = m_addr + 32'(m_t - 1);
          e_ram_dout = m_data[8*(m_t-1) +: 8];
        end else begin
          e_mem_available = 1; e_data_out = '0;
        end
      end else if (m_kind != K_NONE) begin
        if (m_t <= m_n + 1) begin
          e_a_chk = 1;
          e_ram_a = m_addr + 32'(((m_t < m_n) ? m_t : m_n) - 1);
          e_mem_working = (m_kind == K_LOAD);
        end else begin
          m_word = '0;
          for (int k = 0; k < m_n; k++) m_word[8*k +: 8] = ref_rd(m_addr + 32'(k));
          if (m_kind == K_LOAD) begin
            e_mem_available = 1; e_data_out = m_word;
          end else begin
            e_if_valid = 1; e_if_data = m_word;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("if_valid",      32'(if_valid),      32'(e_if_valid));
      check("if_data",       if_data,            e_if_data);
      check("addr_needed",   32'(addr_needed),   32'(e_addr_needed));
      check("mem_working",   32'(mem_working),   32'(e_mem_working));
      check("mem_available", 32'(mem_available), 32'(e_mem_available));
      check("data_out",      data_out,           e_data_out);
      check("ram_wr",        32'(ram_wr),        32'(e_ram_wr));
      if (e_a_chk)  check("ram_a",    ram_a,          e_ram_a);
      if (e_ram_wr) check("ram_dout", 32'(ram_dout),  32'(e_ram_dout));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  // Advance to the next falling edge and retire requests the model says are done.
  task automatic step();
    @(negedge clk);
    if (m_acc_mem)  mem_cnf = 2'd0;
    if (e_if_valid) if_req  = 1'b0;
  endtask

  task automatic mem_req(input logic [1:0] cnf, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
    mem_cnf = cnf; mem_wr = wr; mem_addr = a; mem_data = d;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 63));
      1:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      default: return 32'h0000_0100 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  int seen;
  bit v6;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_cnf = 2'd0; mem_wr = 1'b0; mem_addr = '0; mem_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_addr_needed", 32'(addr_needed), 32'd0);
    check("rst_ram_a",       ram_a,            32'd0);
    check("rst_data_out",    data_out,         32'd0);
    rst = 1'b1;
    step();

    // LW 0x100 -> 0x44332211 in cycle 6
    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    mem_req(2'd3, 1'b0, 32'h100, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) check("lw_ram_a", ram_a, 32'h100 + 32'(c - 1));
      if (c <= 5) check("lw_working", 32'(mem_working), 32'd1);
      if (c == 6) begin
        check("lw_avail", 32'(mem_available), 32'd1);
        check("lw_data",  data_out,           32'h4433_2211);
      end
    end
    repeat (2) step();

    // SH 0x200 <- 0xDEADBEEF
    preload(32'h202, 8'h77);
    mem_req(2'd2, 1'b1, 32'h200, 32'hDEAD_BEEF);
    step();
    check("sh_c1_wr",   32'(ram_wr),   32'd1);
    check("sh_c1_a",    ram_a,         32'h200);
    check("sh_c1_dout", 32'(ram_dout), 32'hEF);
    step();
    check("sh_c2_a",    ram_a,         32'h201);
    check("sh_c2_dout", 32'(ram_dout), 32'hBE);
    step();
    check("sh_avail",   32'(mem_available), 32'd1);
    check("sh_data",    data_out,           32'd0);
    check("sh_untouch", 32'(ram_rd(32'h202)), 32'h77);
    repeat (2) step();

    // Priority: LB wins over a simultaneous fetch
    preload(32'h10, 8'h80);
    preload(32'h0, 8'h01); preload(32'h1, 8'h02); preload(32'h2, 8'h03); preload(32'h3, 8'h04);
    mem_req(2'd1, 1'b0, 32'h10, 32'h0);
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 3) begin
        check("pri_lb_avail", 32'(mem_available), 32'd1);
        check("pri_lb_data",  data_out,           32'h0000_0080);
      end
      if (c == 9) begin
        check("pri_if_valid", 32'(if_valid), 32'd1);
        check("pri_if_data",  if_data,       32'h0403_0201);
      end
    end
    repeat (2) step();

    // MEM request arriving during a fetch waits for DONE_I, then starts at once
    if_req = 1'b1; if_addr = 32'h300;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 2) mem_req(2'd3, 1'b1, 32'h400, 32'hCAFE_F00D);
      if (c >= 2 && c <= 5) begin
        check("mf_addr_needed", 32'(addr_needed), 32'd0);
        check("mf_working",     32'(mem_working), 32'd0);
      end
      if (c == 6) begin
        check("mf_if_valid", 32'(if_valid),    32'd1);
        check("mf_ready",    32'(addr_needed), 32'd1);
      end
      if (c == 7) begin
        check("mf_sw_working", 32'(mem_working), 32'd1);
        check("mf_sw_a",       ram_a,            32'h400);
        check("mf_sw_dout",    32'(ram_dout),    32'h0D);
      end
    end
    repeat (6) step();

    // Reset in cycle 3 of an LW: no completion, all outputs zero
    mem_req(2'd3, 1'b0, 32'h100, 32'h0);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rm_avail",  32'(mem_available), 32'd0);
    check("rm_work",   32'(mem_working),   32'd0);
    check("rm_ready",  32'(addr_needed),   32'd0);
    check("rm_data",   data_out,           32'd0);
    check("rm_ram_a",  ram_a,              32'd0);
    check("rm_if",     if_data,            32'd0);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (mem_available) seen++;
    end
    check("rm_no_avail", 32'(seen), 32'd0);

    // Fetch with if_req dropped in cycle 2
    if_req = 1'b1; if_addr = 32'h500;
    step(); step();
    if_req = 1'b0;
    seen = 0; v6 = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      step();
      if (if_valid) seen++;
      if (ram_wr) seen += 100;
      if (c == 6) v6 = if_valid;
`ifdef MEMCTRL_IF_ABORT_EN
      if (c == 3) check("ab_ready", 32'(addr_needed), 32'd1);
`endif
    end
`ifdef MEMCTRL_IF_ABORT_EN
    check("ab_no_valid", 32'(seen), 32'd0);
`else
    check("nab_valid_c6", 32'(v6),   32'd1);
    check("nab_one_pulse", 32'(seen), 32'd1);
`endif

    // Wrap-around LW at the top of the address space
    preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hB2);
    preload(32'h0000_0000, 8'hC3); preload(32'h0000_0001, 8'hD4);
    mem_req(2'd3, 1'b0, 32'hFFFF_FFFE, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 3) check("wrap_a", ram_a, 32'h0);
      if (c == 6) check("wrap_data", data_out, 32'hD4C3_B2A1);
    end

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst = 1'b0;
      if (mem_cnf == 2'd0 && $urandom_range(0, 3) == 0)
        mem_req(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), rand_addr(), $urandom());
      if (!if_req && $urandom_range(0, 4) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
`ifdef MEMCTRL_IF_ABORT_EN
      else if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
`endif
    end
    rst = 1'b1;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
